l2_arbiter: RTL and testbench

//  Two-port arbiter sharing the single L2 cache port between the L1 I-cache and L1 D-cache miss paths.

---
 rtl/l2_arbiter.sv | 145 ++++++++++++++
 tb/tb_l2_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_arbiter.sv
// l2_arbiter
//   Shares the single L2 cache port between the L1 I-cache and L1 D-cache
//   miss paths. It accepts one miss at a time and latches its command
//   (op, address, write line). It holds the L2 strobe until l2_resp, then
//   routes a one-cycle resp pulse back to the owning requester.
//
// Configuration macro:
//   L2_ARB_RR_EN  defined   -> round-robin on simultaneous requests
//                 undefined -> fixed priority, D-cache over I-cache
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   icache_read/address           I-cache line-fill request
//   icache_rdata/resp             returned line and completion pulse
//   dcache_read/write/address     D-cache fill / writeback request
//   dcache_wdata                  D-cache writeback line
//   dcache_rdata/resp             returned line and completion pulse
//   l2_read/write                 registered strobes to L2, held until l2_resp
//   l2_address/wdata              latched command fields
//   l2_rdata/resp                 line and completion pulse from L2
//
// States:
//   IDLE    | requests sampled, grant decided
//   SERVE_I | I-cache command outstanding at L2
//   SERVE_D | D-cache command outstanding at L2
//   DRAIN   | one dead cycle after an aborted transaction
module l2_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              icache_read,
  input  logic [ADDR_W-1:0] icache_address,
  output logic [LINE_W-1:0] icache_rdata,
  output logic              icache_resp,
  input  logic              dcache_read,
  input  logic              dcache_write,
  input  logic [ADDR_W-1:0] dcache_address,
  input  logic [LINE_W-1:0] dcache_wdata,
  output logic [LINE_W-1:0] dcache_rdata,
  output logic              dcache_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_address,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DRAIN} state_t;

  state_t state, state_nxt;
  logic   last_grant;  // 0 = I-cache, 1 = D-cache
  logic   abort;
  logic   i_req, d_req;
  logic   grant_i, grant_d;
  logic   serving, serve_req;

  assign i_req     = icache_read;
  assign d_req     = dcache_read | dcache_write;
  assign serving   = (state == SERVE_I) || (state == SERVE_D);
  // The owner's request as seen right now; a low here means it walked away.
  assign serve_req = (state == SERVE_I) ? i_req :
                     (state == SERVE_D) ? d_req : 1'b0;

`ifndef L2_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_address <= '0;
      l2_wdata   <= '0;
      last_grant <= 1'b0;
      abort      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_i) begin
        l2_read    <= 1'b1;
        l2_write   <= 1'b0;
        l2_address <= icache_address;
        last_grant <= 1'b0;
        abort      <= 1'b0;
      end else if (grant_d) begin
        // Read and write together is illegal; the write wins.
        l2_read    <= dcache_read & ~dcache_write;
        l2_write   <= dcache_write;
        l2_address <= dcache_address;
        l2_wdata   <= dcache_wdata;
        last_grant <= 1'b1;
        abort      <= 1'b0;
      end else if (serving) begin
        if (l2_resp) begin
          l2_read  <= 1'b0;
          l2_write <= 1'b0;
        end else if (!serve_req) begin
          abort <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    case (state)
      IDLE: begin
`ifdef L2_ARB_RR_EN
        if (i_req && d_req) begin
          grant_i = last_grant;
          grant_d = ~last_grant;
        end else begin
          grant_i = i_req;
          grant_d = d_req;
        end
`else
        grant_d = d_req;
        grant_i = i_req & ~d_req;
`endif
        if (grant_i)      state_nxt = SERVE_I;
        else if (grant_d) state_nxt = SERVE_D;
      end
      SERVE_I, SERVE_D: begin
        // A drop in the very cycle of l2_resp also counts as an abort.
        if (l2_resp) state_nxt = (abort || !serve_req) ? DRAIN : IDLE;
      end
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    icache_rdata = l2_rdata;
    dcache_rdata = l2_rdata;
    icache_resp  = (state == SERVE_I) && l2_resp && !abort && i_req;
    dcache_resp  = (state == SERVE_D) && l2_resp && !abort && d_req;
  end

endmodule

// File: tb/tb_l2_arbiter.sv
module tb_l2_arbiter;
  localparam int AW = 16;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          icache_read;
  logic [AW-1:0] icache_address;
  logic [LW-1:0] icache_rdata;
  logic          icache_resp;
  logic          dcache_read;
  logic          dcache_write;
  logic [AW-1:0] dcache_address;
  logic [LW-1:0] dcache_wdata;
  logic [LW-1:0] dcache_rdata;
  logic          dcache_resp;
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_address;
  logic [LW-1:0] l2_wdata;
  logic [LW-1:0] l2_rdata;
  logic          l2_resp;

  int checks = 0;
  int errors = 0;
  bit model_last_d = 1'b0;  // reference model of who was granted last

  l2_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk(clk), .reset(reset),
    .icache_read(icache_read), .icache_address(icache_address),
    .icache_rdata(icache_rdata), .icache_resp(icache_resp),
    .dcache_read(dcache_read), .dcache_write(dcache_write),
    .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
    .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference arbitration rule: 1 = D-cache wins.
  function automatic bit predict_d(bit i, bit d);
    if (i && d) begin
`ifdef L2_ARB_RR_EN
      return !model_last_d;
`else
      return 1'b1;
`endif
    end
    return d;
  endfunction

  // Acts as the L2: waits (bounded) for a strobe, answers after lat cycles,
  // and reports what the arbiter presented and returned.
  task automatic l2_transact(input int lat, input logic [LW-1:0] line,
                             output int waited, output logic rd, output logic wr,
                             output logic [AW-1:0] addr, output logic [LW-1:0] wd,
                             output bit held_ok, output logic ir, output logic dr,
                             output logic [LW-1:0] ird, output logic [LW-1:0] drd);
    waited = 0;
    held_ok = 1'b1;
    while (!(l2_read || l2_write) && waited < 20) begin
      cyc();
      waited++;
    end
    rd = l2_read; wr = l2_write; addr = l2_address; wd = l2_wdata;
    for (int k = 1; k < lat; k++) begin
      cyc();
      if (l2_read !== rd || l2_write !== wr || l2_address !== addr || l2_wdata !== wd)
        held_ok = 1'b0;
    end
    l2_rdata = line;
    l2_resp = 1'b1;
    #1;
    ir = icache_resp; dr = dcache_resp; ird = icache_rdata; drd = dcache_rdata;
    cyc();
    l2_resp = 1'b0;
    l2_rdata = rand_line();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    checks++;
    if (l2_read !== 1'b0 || l2_write !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got rd=%b wr=%b exp 0 0", l2_read, l2_write);
    end
    checks++;
    if (l2_address !== '0 || l2_wdata !== '0) begin
      errors++; $display("FAIL reset_fields got addr=%h wdata=%h exp 0", l2_address, l2_wdata);
    end
    checks++;
    if (icache_resp !== 1'b0 || dcache_resp !== 1'b0) begin
      errors++; $display("FAIL reset_resp got i=%b d=%b exp 0 0", icache_resp, dcache_resp);
    end
    reset = 1'b0;
    model_last_d = 1'b0;
    cyc();
  endtask

  task automatic test_i_only();
    int w; logic rd, wr, ir, dr; logic [AW-1:0] a; logic [LW-1:0] wd, ird, drd, line;
    bit h;
    line = rand_line();
    icache_read = 1'b1; icache_address = 16'h1230;
    l2_transact(4, line, w, rd, wr, a, wd, h, ir, dr, ird, drd);
    icache_read = 1'b0;
    model_last_d = 1'b0;
    checks++;
    if (w !== 1) begin errors++; $display("FAIL i_only_latency got %0d exp 1", w); end
    checks++;
    if (rd !== 1'b1 || wr !== 1'b0 || a !== 16'h1230) begin
      errors++; $display("FAIL i_only_cmd got rd=%b wr=%b a=%h exp 1 0 1230", rd, wr, a);
    end
    checks++;
    if (!h) begin errors++; $display("FAIL i_only_hold got changed exp held"); end
    checks++;
    if (ir !== 1'b1 || dr !== 1'b0 || ird !== line) begin
      errors++; $display("FAIL i_only_resp got i=%b d=%b data=%h exp 1 0 %h", ir, dr, ird, line);
    end
    checks++;
    if (l2_read !== 1'b0 || icache_resp !== 1'b0) begin
      errors++; $display("FAIL i_only_clear got rd=%b resp=%b exp 0 0", l2_read, icache_resp);
    end
    cyc();
  endtask

  task automatic test_d_writeback(input bit also_read);
    int w; logic rd, wr, ir, dr; logic [AW-1:0] a; logic [LW-1:0] wd, ird, drd, line, wv;
    bit h;
    line = rand_line(); wv = rand_line();
    dcache_write = 1'b1; dcache_read = also_read;
    dcache_address = 16'h4450; dcache_wdata = wv;
    l2_transact(3, line, w, rd, wr, a, wd, h, ir, dr, ird, drd);
    dcache_write = 1'b0; dcache_read = 1'b0;
    model_last_d = 1'b1;
    checks++;
    if (rd !== 1'b0 || wr !== 1'b1 || a !== 16'h4450 || wd !== wv || w !== 1) begin
      errors++;
      $display("FAIL d_write_cmd(rw=%0b) got rd=%b wr=%b a=%h w=%0d exp 0 1 4450 1", also_read, rd, wr, a, w);
    end
    checks++;
    if (!h) begin errors++; $display("FAIL d_write_hold got changed exp held"); end
    checks++;
    if (dr !== 1'b1 || ir !== 1'b0) begin
      errors++; $display("FAIL d_write_resp got i=%b d=%b exp 0 1", ir, dr);
    end
    cyc();
  endtask

  task automatic test_simultaneous();
    int w; logic rd, wr, ir, dr; logic [AW-1:0] a, ea, ia, da; logic [LW-1:0] wd, ird, drd, line;
    bit h, ed, pi, pd;
    ia = 16'h0110; da = 16'h0220;
    icache_read = 1'b1; icache_address = ia;
    dcache_read = 1'b1; dcache_address = da;
    pi = 1'b1; pd = 1'b1;
    for (int t = 0; t < 2; t++) begin
      ed = predict_d(pi, pd);
      ea = ed ? da : ia;
      line = rand_line();
      l2_transact(2, line, w, rd, wr, a, wd, h, ir, dr, ird, drd);
      model_last_d = ed;
      checks++;
      if (a !== ea || w !== 1) begin
        errors++; $display("FAIL simul_order[%0d] got a=%h w=%0d exp %h 1", t, a, w, ea);
      end
      checks++;
      if (ir !== !ed || dr !== ed || (ed ? drd : ird) !== line) begin
        errors++; $display("FAIL simul_resp[%0d] got i=%b d=%b exp i=%b d=%b", t, ir, dr, !ed, ed);
      end
      if (ed) begin dcache_read = 1'b0; pd = 1'b0; end
      else begin icache_read = 1'b0; pi = 1'b0; end
    end
    cyc();
  endtask

  task automatic test_both_held();
    int w; logic rd, wr, ir, dr; logic [AW-1:0] a; logic [LW-1:0] wd, ird, drd;
    bit h, ed;
    // Make the D-cache the last grantee first.
    dcache_read = 1'b1; dcache_address = 16'h0330;
    l2_transact(1, rand_line(), w, rd, wr, a, wd, h, ir, dr, ird, drd);
    model_last_d = 1'b1;
    checks++;
    if (dr !== 1'b1 || a !== 16'h0330) begin
      errors++; $display("FAIL held_prime got d=%b a=%h exp 1 0330", dr, a);
    end
    icache_read = 1'b1; icache_address = 16'h0440;
    for (int t = 0; t < 3; t++) begin
      ed = predict_d(1'b1, 1'b1);
      l2_transact(2, rand_line(), w, rd, wr, a, wd, h, ir, dr, ird, drd);
      model_last_d = ed;
      checks++;
      if (a !== (ed ? 16'h0330 : 16'h0440) || dr !== ed || ir !== !ed || w !== 1) begin
        errors++; $display("FAIL held_seq[%0d] got a=%h i=%b d=%b w=%0d exp d=%b", t, a, ir, dr, w, ed);
      end
    end
    icache_read = 1'b0; dcache_read = 1'b0;
    cyc();
  endtask

  task automatic test_abort();
    int w; logic rd, wr, ir, dr; logic [AW-1:0] a; logic [LW-1:0] wd, ird, drd, line;
    bit h;
    icache_read = 1'b1; icache_address = 16'h2340;
    cyc();
    model_last_d = 1'b0;
    checks++;
    if (l2_read !== 1'b1) begin errors++; $display("FAIL abort_grant got %b exp 1", l2_read); end
    cyc(); cyc();
    icache_read = 1'b0;
    cyc();
    checks++;
    if (l2_read !== 1'b1 || l2_address !== 16'h2340) begin
      errors++; $display("FAIL abort_hold got rd=%b a=%h exp 1 2340", l2_read, l2_address);
    end
    l2_rdata = rand_line(); l2_resp = 1'b1;
    #1;
    checks++;
    if (icache_resp !== 1'b0) begin errors++; $display("FAIL abort_resp got %b exp 0", icache_resp); end
    cyc();
    l2_resp = 1'b0;
    // A request presented during DRAIN must wait one extra cycle.
    icache_read = 1'b1; icache_address = 16'h5670;
    checks++;
    if (l2_read !== 1'b0) begin errors++; $display("FAIL abort_clear got %b exp 0", l2_read); end
    line = rand_line();
    l2_transact(2, line, w, rd, wr, a, wd, h, ir, dr, ird, drd);
    icache_read = 1'b0;
    model_last_d = 1'b0;
    checks++;
    if (w !== 2) begin errors++; $display("FAIL abort_drain_latency got %0d exp 2", w); end
    checks++;
    if (ir !== 1'b1 || ird !== line || a !== 16'h5670) begin
      errors++; $display("FAIL abort_next got i=%b a=%h exp 1 5670", ir, a);
    end
    cyc();
  endtask

  task automatic test_reset_mid_serve();
    int w; logic rd, wr, ir, dr; logic [AW-1:0] a; logic [LW-1:0] wd, ird, drd;
    bit h;
    dcache_read = 1'b1; dcache_address = 16'h6780;
    cyc();
    checks++;
    if (l2_read !== 1'b1) begin errors++; $display("FAIL rst_mid_grant got %b exp 1", l2_read); end
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0; dcache_read = 1'b0;
    model_last_d = 1'b0;
    checks++;
    if (l2_read !== 1'b0 || l2_write !== 1'b0) begin
      errors++; $display("FAIL rst_mid_strobes got rd=%b wr=%b exp 0 0", l2_read, l2_write);
    end
    l2_rdata = rand_line(); l2_resp = 1'b1;
    #1;
    checks++;
    if (dcache_resp !== 1'b0 || icache_resp !== 1'b0) begin
      errors++; $display("FAIL rst_mid_stale_resp got d=%b i=%b exp 0 0", dcache_resp, icache_resp);
    end
    cyc();
    l2_resp = 1'b0;
    icache_read = 1'b1; icache_address = 16'h7890;
    l2_transact(1, rand_line(), w, rd, wr, a, wd, h, ir, dr, ird, drd);
    icache_read = 1'b0;
    checks++;
    if (w !== 1 || ir !== 1'b1 || a !== 16'h7890) begin
      errors++; $display("FAIL rst_mid_recover got w=%0d i=%b a=%h exp 1 1 7890", w, ir, a);
    end
    cyc();
  endtask

  task automatic test_random();
    int w, lat, dop; logic rd, wr, ir, dr; logic [AW-1:0] a, ia, da, ea;
    logic [LW-1:0] wd, ird, drd, line, dw;
    bit h, ed, pi, pd, ewr;
    for (int r = 0; r < 40; r++) begin
      pi = 1'($urandom_range(0, 1));
      pd = 1'($urandom_range(0, 1));
      if (!pi && !pd) pi = 1'b1;
      dop = $urandom_range(0, 2);  // 0 read, 1 write, 2 both (acts as write)
      ia = 16'($urandom); da = 16'($urandom); dw = rand_line();
      icache_read = pi; icache_address = ia;
      dcache_read = pd && dop != 1; dcache_write = pd && dop != 0;
      dcache_address = da; dcache_wdata = dw;
      while (pi || pd) begin
        ed = predict_d(pi, pd);
        ea = ed ? da : ia;
        ewr = ed && dop != 0;
        lat = $urandom_range(1, 5);
        line = rand_line();
        l2_transact(lat, line, w, rd, wr, a, wd, h, ir, dr, ird, drd);
        model_last_d = ed;
        checks++;
        if (w !== 1 || a !== ea || wr !== ewr || rd !== !ewr || (ewr && wd !== dw)) begin
          errors++;
          $display("FAIL rand_cmd[%0d] got w=%0d a=%h rd=%b wr=%b exp a=%h wr=%b", r, w, a, rd, wr, ea, ewr);
        end
        checks++;
        if (!h || ir !== !ed || dr !== ed || (ed ? drd : ird) !== line) begin
          errors++; $display("FAIL rand_resp[%0d] got i=%b d=%b hold=%b exp d=%b", r, ir, dr, h, ed);
        end
        if (ed) begin dcache_read = 1'b0; dcache_write = 1'b0; pd = 1'b0; end
        else begin icache_read = 1'b0; pi = 1'b0; end
      end
      cyc();
    end
  endtask

  initial begin
    reset = 1'b1;
    icache_read = 1'b0; icache_address = '0;
    dcache_read = 1'b0; dcache_write = 1'b0; dcache_address = '0; dcache_wdata = '0;
    l2_rdata = '0; l2_resp = 1'b0;
    test_reset();
    test_i_only();
    test_d_writeback(1'b0);
    test_d_writeback(1'b1);
    test_simultaneous();
    test_both_held();
    test_abort();
    test_reset_mid_serve();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
